// File: rtl/router_port_reader.sv
// router_port_reader
//   Consumer end of one router output port. Drains packets of the form
//   {len[5:0], addr[1:0]} header, len payload bytes, XOR parity byte from the
//   router FIFO, re-emits the payload as a framed byte stream, and reports
//   per-packet status plus running packet/error counters.
//
// Ports
//   clk, resetn          rising-edge clock, asynchronous active-low reset
//   enable               allows a new packet to start (looked at in IDLE only)
//   valid_out, data_out  router FIFO not-empty flag and read data (data is
//                        valid the cycle after read_en)
//   read_en              FIFO read strobe, combinational
//   byte_valid/data/sof/eof   registered payload stream, no backpressure
//   pkt_done             one-cycle status strobe; pkt_len, pkt_addr and the
//                        error flags are updated with it and held until the
//                        next one
//   pkt_count, err_count completed packets (wrapping) and errored packets
//                        (saturating)
module router_port_reader #(
  parameter logic [1:0]  PORT_ID   = 2'd0,
  parameter int unsigned STALL_MAX = 64
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        enable,
  input  logic        valid_out,
  input  logic [7:0]  data_out,
  output logic        read_en,
  output logic        byte_valid,
  output logic [7:0]  byte_data,
  output logic        byte_sof,
  output logic        byte_eof,
  output logic        pkt_done,
  output logic [5:0]  pkt_len,
  output logic [1:0]  pkt_addr,
  output logic        parity_err,
  output logic        addr_err,
  output logic        trunc_err,
  output logic [15:0] pkt_count,
  output logic [15:0] err_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_BODY = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Last stall-counter value before the abort fires: the abort is taken in
  // the STALL_MAX-th consecutive starved cycle.
  localparam logic [7:0] STALL_LAST = 8'(STALL_MAX - 32'd1);

  function automatic logic [7:0] parity_fold(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

  state_t      state_r;
  logic        rd_pend_r;
  logic [5:0]  len_r;
  logic [1:0]  addr_r;
  logic [7:0]  acc_r;
  logic [6:0]  req_left_r;   // reads still to issue (payload + parity)
  logic [6:0]  rx_left_r;    // captures still to receive (payload + parity)
  logic [7:0]  stall_r;
  logic        first_r;      // next forwarded byte is the first of the packet

  logic        byte_valid_r;
  logic [7:0]  byte_data_r;
  logic        byte_sof_r;
  logic        byte_eof_r;
  logic        pkt_done_r;
  logic [5:0]  pkt_len_r;
  logic [1:0]  pkt_addr_r;
  logic        parity_err_r;
  logic        addr_err_r;
  logic        trunc_err_r;
  logic [15:0] pkt_count_r;
  logic [15:0] err_count_r;

  logic        read_en_s;
  logic        starved_s;
  logic        stall_hit_s;

  // Read strobe: the state decides whether a read is wanted, valid_out gates it.
  always_comb begin
    read_en_s = 1'b0;
    case (state_r)
      ST_IDLE: read_en_s = enable & valid_out;
      ST_BODY: read_en_s = (req_left_r != 7'd0) & valid_out;
      default: read_en_s = 1'b0;
    endcase
  end

  assign starved_s   = (state_r == ST_BODY) && (req_left_r != 7'd0) && !valid_out;
  assign stall_hit_s = starved_s && (stall_r == STALL_LAST);

  // Packet FSM, byte stream, status and counters.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r      <= ST_IDLE;
      rd_pend_r    <= 1'b0;
      len_r        <= 6'd0;
      addr_r       <= 2'd0;
      acc_r        <= 8'd0;
      req_left_r   <= 7'd0;
      rx_left_r    <= 7'd0;
      stall_r      <= 8'd0;
      first_r      <= 1'b0;
      byte_valid_r <= 1'b0;
      byte_data_r  <= 8'd0;
      byte_sof_r   <= 1'b0;
      byte_eof_r   <= 1'b0;
      pkt_done_r   <= 1'b0;
      pkt_len_r    <= 6'd0;
      pkt_addr_r   <= 2'd0;
      parity_err_r <= 1'b0;
      addr_err_r   <= 1'b0;
      trunc_err_r  <= 1'b0;
      pkt_count_r  <= 16'd0;
      err_count_r  <= 16'd0;
    end else begin
      rd_pend_r    <= read_en_s;
      byte_valid_r <= 1'b0;
      byte_sof_r   <= 1'b0;
      byte_eof_r   <= 1'b0;
      pkt_done_r   <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (read_en_s) begin
            state_r <= ST_HDR;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_HDR: begin
          // The header read was issued in IDLE, so data_out holds it now.
          len_r      <= data_out[7:2];
          addr_r     <= data_out[1:0];
          acc_r      <= data_out;
          req_left_r <= {1'b0, data_out[7:2]} + 7'd1;
          rx_left_r  <= {1'b0, data_out[7:2]} + 7'd1;
          stall_r    <= 8'd0;
          first_r    <= 1'b1;
          state_r    <= ST_BODY;
        end
        ST_BODY: begin
          if (read_en_s) begin
            req_left_r <= req_left_r - 7'd1;
            stall_r    <= 8'd0;
          end else if (starved_s) begin
            stall_r <= stall_r + 8'd1;
          end else begin
            stall_r <= stall_r;
          end
          if (stall_hit_s) begin
            // Abort: any capture landing this cycle is deliberately dropped.
            trunc_err_r  <= 1'b1;
            parity_err_r <= 1'b0;
            addr_err_r   <= (addr_r != PORT_ID);
            pkt_len_r    <= len_r;
            pkt_addr_r   <= addr_r;
            pkt_done_r   <= 1'b1;
            state_r      <= ST_DONE;
          end else if (rd_pend_r) begin
            rx_left_r <= rx_left_r - 7'd1;
            if (rx_left_r > 7'd1) begin
              acc_r        <= parity_fold(acc_r, data_out);
              byte_valid_r <= 1'b1;
              byte_data_r  <= data_out;
              byte_sof_r   <= first_r;
              byte_eof_r   <= (rx_left_r == 7'd2);
              first_r      <= 1'b0;
            end else begin
              parity_err_r <= (data_out != acc_r);
              addr_err_r   <= (addr_r != PORT_ID);
              trunc_err_r  <= 1'b0;
              pkt_len_r    <= len_r;
              pkt_addr_r   <= addr_r;
              pkt_done_r   <= 1'b1;
              state_r      <= ST_DONE;
            end
          end else begin
            state_r <= ST_BODY;
          end
        end
        ST_DONE: begin
          pkt_count_r <= pkt_count_r + 16'd1;
          if ((parity_err_r || addr_err_r || trunc_err_r) && (err_count_r != 16'hFFFF)) begin
            err_count_r <= err_count_r + 16'd1;
          end else begin
            err_count_r <= err_count_r;
          end
          state_r <= ST_IDLE;
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  assign read_en    = read_en_s;
  assign byte_valid = byte_valid_r;
  assign byte_data  = byte_data_r;
  assign byte_sof   = byte_sof_r;
  assign byte_eof   = byte_eof_r;
  assign pkt_done   = pkt_done_r;
  assign pkt_len    = pkt_len_r;
  assign pkt_addr   = pkt_addr_r;
  assign parity_err = parity_err_r;
  assign addr_err   = addr_err_r;
  assign trunc_err  = trunc_err_r;
  assign pkt_count  = pkt_count_r;
  assign err_count  = err_count_r;

endmodule

// File: tb/tb_router_port_reader.sv
// Scoreboard bench for router_port_reader. A FIFO model feeds the DUT; each
// queued packet pushes its expected payload bytes and status to queues that a
// negedge monitor pops as the DUT produces output.
module tb_router_port_reader;

  localparam int STALL = 8;

  logic        clk;
  logic        resetn;
  logic        enable;
  logic        valid_out;
  logic [7:0]  data_out;
  logic        read_en;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_sof;
  logic        byte_eof;
  logic        pkt_done;
  logic [5:0]  pkt_len;
  logic [1:0]  pkt_addr;
  logic        parity_err;
  logic        addr_err;
  logic        trunc_err;
  logic [15:0] pkt_count;
  logic [15:0] err_count;

  router_port_reader #(.PORT_ID(2'd0), .STALL_MAX(STALL)) dut (
    .clk(clk), .resetn(resetn), .enable(enable), .valid_out(valid_out),
    .data_out(data_out), .read_en(read_en), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_sof(byte_sof), .byte_eof(byte_eof),
    .pkt_done(pkt_done), .pkt_len(pkt_len), .pkt_addr(pkt_addr),
    .parity_err(parity_err), .addr_err(addr_err), .trunc_err(trunc_err),
    .pkt_count(pkt_count), .err_count(err_count)
  );

  typedef struct {
    logic [7:0] data;
    logic       sof;
    logic       eof;
    int         off;
  } byte_exp_t;

  typedef struct {
    logic [5:0] len;
    logic [1:0] addr;
    logic       perr;
    logic       aerr;
    logic       terr;
    int         done_off;
    int         reads;
  } stat_exp_t;

  byte_exp_t  bq[$];
  stat_exp_t  sq[$];
  logic [7:0] fifo[$];

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  int t0 = -1;
  int rd_mon = 0;
  int done_seen = 0;
  int en0_reads = 0;
  bit mon_en = 1'b0;
  bit chk_cnt = 1'b0;
  logic [15:0] m_pkt = 16'd0;
  logic [15:0] m_err = 16'd0;
  int rd_drv = 0;
  int gap_at = 0;
  int gap_len = 0;
  int gap_left = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // FIFO model: a read seen at a rising edge delivers data shortly after it.
  initial begin : drv
    bit fired;
    valid_out = 1'b0;
    data_out = 8'h00;
    forever begin
      @(posedge clk);
      fired = read_en;
      #1;
      if (fired && fifo.size() > 0) begin
        data_out = fifo.pop_front();
        rd_drv++;
        if (rd_drv == gap_at) gap_left = gap_len;
      end
      if (gap_left > 0) begin
        valid_out = 1'b0;
        gap_left--;
      end else begin
        valid_out = (fifo.size() != 0);
      end
    end
  end

  // Monitor: cycle offsets are relative to the packet's first read_en cycle.
  initial begin : mon
    byte_exp_t e;
    stat_exp_t s;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (chk_cnt) begin
          chk_cnt = 1'b0;
          check_eq("pkt_count", pkt_count, m_pkt);
          check_eq("err_count", err_count, m_err);
        end
        if (!enable && read_en) en0_reads++;
        if (read_en) begin
          if (t0 < 0) t0 = cyc;
          rd_mon++;
        end
        if (byte_valid) begin
          if (bq.size() == 0) begin
            check_eq("byte_extra", byte_valid, 1'b0);
          end else begin
            e = bq.pop_front();
            check_eq("byte_data", byte_data, e.data);
            check_eq("byte_sof", byte_sof, e.sof);
            check_eq("byte_eof", byte_eof, e.eof);
            check_eq("byte_cycle", cyc - t0, e.off);
          end
        end
        if (pkt_done) begin
          if (sq.size() == 0) begin
            check_eq("done_extra", pkt_done, 1'b0);
          end else begin
            s = sq.pop_front();
            check_eq("pkt_len", pkt_len, s.len);
            check_eq("pkt_addr", pkt_addr, s.addr);
            check_eq("parity_err", parity_err, s.perr);
            check_eq("addr_err", addr_err, s.aerr);
            check_eq("trunc_err", trunc_err, s.terr);
            check_eq("done_cycle", cyc - t0, s.done_off);
            check_eq("read_count", rd_mon, s.reads);
            check_eq("bytes_missing", bq.size(), 0);
            m_pkt = m_pkt + 16'd1;
            if ((s.perr || s.aerr || s.terr) && m_err != 16'hFFFF) m_err = m_err + 16'd1;
          end
          t0 = -1;
          rd_mon = 0;
          done_seen++;
          chk_cnt = 1'b1;
        end
      end
    end
  end

  // Queue one packet in the FIFO model and its expectations in the scoreboard.
  // A gap of g_len cycles follows read number g_at (header is read 1).
  task automatic queue_pkt(input logic [5:0] len, input logic [1:0] addr, input bit bad_par,
                           input int g_at, input int g_len, input bit seq);
    logic [7:0] hdr;
    logic [7:0] acc;
    logic [7:0] b;
    logic [7:0] par;
    bit trunc;
    byte_exp_t e;
    stat_exp_t s;
    hdr = {len, addr};
    acc = hdr;
    trunc = (g_at >= 2) && (g_at <= int'(len) + 1) && (g_len >= STALL);
    rd_drv = 0;
    gap_at = g_at;
    gap_len = g_len;
    fifo.push_back(hdr);
    for (int k = 0; k < int'(len); k++) begin
      b = seq ? 8'(k + 1) : 8'($urandom);
      acc = acc ^ b;
      fifo.push_back(b);
      if (!trunc || (k + 2) <= g_at) begin
        e.data = b;
        e.sof = (k == 0);
        e.eof = (k == int'(len) - 1) && !trunc;
        e.off = 4 + k + (((g_at > 0) && (k + 2 > g_at)) ? g_len : 0);
        bq.push_back(e);
      end
    end
    par = bad_par ? 8'h00 : acc;
    fifo.push_back(par);
    s.len = len;
    s.addr = addr;
    s.perr = !trunc && (par != acc);
    s.aerr = (addr != 2'd0);
    s.terr = trunc;
    s.done_off = trunc ? (g_at + STALL + 1)
                       : (4 + int'(len) + (((g_at > 0) && (int'(len) + 2 > g_at)) ? g_len : 0));
    s.reads = trunc ? g_at : int'(len) + 2;
    sq.push_back(s);
  endtask

  task automatic wait_done();
    int start;
    start = done_seen;
    for (int i = 0; i < 400 && done_seen == start; i++) @(negedge clk);
    check_eq("done_timeout", 32'(done_seen > start), 32'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    resetn = 1'b0;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_read_en", read_en, 1'b0);
    check_eq("rst_byte_valid", byte_valid, 1'b0);
    check_eq("rst_pkt_done", pkt_done, 1'b0);
    check_eq("rst_pkt_count", pkt_count, 16'd0);
    check_eq("rst_err_count", err_count, 16'd0);
    resetn = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;

    // enable low: packet waits in the FIFO, no reads
    queue_pkt(6'd5, 2'd0, 1'b0, 0, 0, 1'b1);
    repeat (6) @(negedge clk);
    check_eq("en0_reads", en0_reads, 0);
    check_eq("en0_valid_out", valid_out, 1'b1);
    @(posedge clk);
    #2 enable = 1'b1;
    wait_done();
    repeat (2) @(negedge clk);

    // bad parity, len 0, len 20 with 3-cycle gap
    queue_pkt(6'd5, 2'd0, 1'b1, 0, 0, 1'b1);
    wait_done();
    repeat (2) @(negedge clk);
    queue_pkt(6'd0, 2'd0, 1'b0, 0, 0, 1'b0);
    wait_done();
    repeat (2) @(negedge clk);
    queue_pkt(6'd20, 2'd0, 1'b0, 7, 3, 1'b0);
    wait_done();
    repeat (2) @(negedge clk);

    // stall timeout, then drop the undelivered remainder
    queue_pkt(6'd10, 2'd0, 1'b0, 5, 200, 1'b0);
    wait_done();
    fifo.delete();
    gap_left = 0;
    gap_at = 0;
    valid_out = 1'b0;
    repeat (2) @(negedge clk);
    queue_pkt(6'd3, 2'd0, 1'b0, 0, 0, 1'b0);
    wait_done();
    repeat (2) @(negedge clk);

    // wrong address, then flags held
    queue_pkt(6'd4, 2'd1, 1'b0, 0, 0, 1'b0);
    wait_done();
    repeat (4) @(negedge clk);
    check_eq("aerr_held", addr_err, 1'b1);
    check_eq("addr_held", pkt_addr, 2'd1);

    // len 1: sof and eof on the same byte
    queue_pkt(6'd1, 2'd0, 1'b0, 0, 0, 1'b0);
    wait_done();
    repeat (2) @(negedge clk);

    // reset in the middle of the payload
    queue_pkt(6'd10, 2'd0, 1'b0, 0, 0, 1'b0);
    for (int i = 0; i < 100 && bq.size() > 7; i++) @(negedge clk);
    check_eq("rst_mid_reached", 32'(bq.size() <= 7), 32'd1);
    mon_en = 1'b0;
    enable = 1'b0;
    resetn = 1'b0;
    #1;
    check_eq("rst_mid_read_en", read_en, 1'b0);
    check_eq("rst_mid_byte_valid", byte_valid, 1'b0);
    check_eq("rst_mid_byte_data", byte_data, 8'd0);
    check_eq("rst_mid_pkt_len", pkt_len, 6'd0);
    check_eq("rst_mid_addr_err", addr_err, 1'b0);
    check_eq("rst_mid_pkt_count", pkt_count, 16'd0);
    check_eq("rst_mid_err_count", err_count, 16'd0);
    fifo.delete();
    bq.delete();
    sq.delete();
    gap_at = 0;
    gap_left = 0;
    valid_out = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    t0 = -1;
    rd_mon = 0;
    chk_cnt = 1'b0;
    m_pkt = 16'd0;
    m_err = 16'd0;
    @(negedge clk);
    mon_en = 1'b1;
    enable = 1'b1;
    queue_pkt(6'd2, 2'd0, 1'b0, 0, 0, 1'b0);
    wait_done();
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/router_port_reader.md
# router_port_reader

Packet reader for one router output port. It drains packets from a router output FIFO via the valid_out/read_en/data_out handshake. Each packet is a header byte {len[5:0], addr[1:0]}, then len payload bytes, then one parity byte (XOR of header and all payload bytes). The block re-emits payload bytes as a framed byte stream, checks parity and address, and reports per-packet status and counters. One instance sits on each of data_out_0/1/2 as the consumer end of the router.

## Interface
Parameters:
- PORT_ID, 2'd0, expected header addr field for this port
- STALL_MAX, 64, consecutive mid-packet cycles with valid_out low before the packet is aborted (legal range 2..255)

Ports:
- clk  in  1  clock, rising edge
- resetn  in  1  asynchronous, active-low reset
- enable  in  1  permits starting a new packet; sampled only in IDLE
- valid_out  in  1  router FIFO non-empty
- data_out  in  8  router FIFO read data; valid the cycle after a read
- read_en  out  1  FIFO read strobe (combinational: state qualifier AND valid_out)
- byte_valid  out  1  payload byte on byte_data
- byte_data  out  8  payload byte
- byte_sof  out  1  first payload byte of packet
- byte_eof  out  1  last payload byte of packet
- pkt_done  out  1  one-cycle status strobe
- pkt_len  out  6  header len of the finished packet
- pkt_addr  out  2  header addr of the finished packet
- parity_err  out  1  received parity ≠ computed XOR; valid with pkt_done
- addr_err  out  1  header addr ≠ PORT_ID; valid with pkt_done
- trunc_err  out  1  packet aborted by stall timeout; valid with pkt_done
- pkt_count  out  16  completed packets including aborted ones; wraps FFFF→0
- err_count  out  16  packets with any error flag set; saturates at FFFF

## Operation
- Read handshake:
  - A read issued in cycle N (read_en=1, which implies valid_out=1) yields data_out valid in cycle N+1.
  - rd_pend is a register holding the previous cycle's read_en. A byte is captured at the end of any cycle with rd_pend=1.
- FSM states IDLE, HDR, BODY, DONE:
  - IDLE: read_en = enable & valid_out. If read_en=1 → HDR.
  - HDR: read_en=0. Capture the header: latch len and addr, set parity accumulator = header, set req_left = len+1, rx_left = len+1. → BODY.
  - BODY: read_en = (req_left≠0) & valid_out. Each read decrements req_left. Each capture decrements rx_left.
    - Captures with rx_left>1 are payload: XOR into the accumulator and forward to the byte stream.
    - The capture with rx_left=1 is parity: compare against the accumulator, then → DONE.
  - DONE: pkt_done=1, error flags driven, counters updated (visible next cycle). → IDLE.
- len=0: BODY issues one read (parity only). No byte_valid occurs.
- Stall timeout:
  - In BODY, a counter increments on each cycle with req_left≠0 and valid_out=0, and clears on any read.
  - On reaching STALL_MAX: trunc_err=1, parity_err=0, → DONE. Any in-flight capture in that cycle is dropped. If payload was already forwarded, byte_eof is not issued.
- addr_err is reported but the packet is still fully drained and forwarded.
- err_count increments when parity_err | addr_err | trunc_err.

## Timing
- Reset values: all outputs 0, counters 0, FSM = IDLE, rd_pend = 0. Reset is asynchronous and may occur mid-packet. After release the block starts in IDLE and makes no attempt to resynchronise to the remainder of the packet.
- Back-to-back timing, with valid_out held high and IDLE entered at cycle 0:
  - read_en high in cycles 0 and 2..2+len.
  - Header captured at the end of cycle 1.
  - Payload byte k (k=0..len-1) is on byte_data in cycle 4+k.
  - Parity captured at the end of cycle 3+len.
  - pkt_done in cycle 4+len.
  - Earliest next header read in cycle 5+len.
- The byte stream is a registered flow with no backpressure.
  - byte_sof coincides with the first byte_valid; byte_eof with the last.
  - For len=1, sof and eof are both set on the same byte.
- pkt_len, pkt_addr and the error flags are held from DONE until the next DONE.
- A valid_out drop in BODY stalls reads without loss. Each cycle of gap delays pkt_done by one cycle.

## Test plan
- Header 0x14 (len5, addr0), PORT_ID=0, payload 01 02 03 04 05, correct parity 0x15, valid_out continuous → read_en in cycles 0 and 2..7; five byte_valid in cycles 4..8 with sof@4 and eof@8; pkt_done@9; pkt_len=5, all errors 0, pkt_count=1.
- Same packet with parity byte 0x00 → parity_err=1, err_count=1, payload still forwarded.
- Header 0x00 (len0), parity 0x00 → exactly two reads, no byte_valid, pkt_done@4, no errors.
- len20 packet with valid_out low for 3 cycles after the 6th payload read → read_en low during the gap, all 20 bytes forwarded in order, pkt_done delayed exactly 3 cycles.
- valid_out held low for STALL_MAX cycles mid-payload → trunc_err=1, no byte_eof, return to IDLE; the next clean packet completes normally.
- Three further checks:
  - enable=0 with valid_out=1 → read_en stays 0.
  - Header addr 2'b01 on a PORT_ID=0 instance → addr_err=1.
  - resetn pulsed mid-BODY → all outputs 0 immediately and FSM in IDLE.
